// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM duty scale, decoder states and divider sizing
package pwm_pkg;

    localparam int DUTY_W     = 4;
    localparam int DUTY_STEPS = 16;

    // One quotient bit per iteration yields the full duty scale.
    localparam int DIV_ITERS  = $clog2(DUTY_STEPS);
    localparam int ITER_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_e;

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// rtl/pwm_duty_decoder_if.sv - measurement result bus of the PWM duty decoder
interface pwm_duty_decoder_if #(
    parameter int CNT_W = 16
) ();
    import pwm_pkg::*;

    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              valid;
    logic              timeout;
    logic              overrun;

    modport master (
        output duty, high_cnt, period_cnt, valid, timeout, overrun
    );

    modport slave (
        input  duty, high_cnt, period_cnt, valid, timeout, overrun
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - input synchronizer with rising-edge detect on the synced line
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Both terms are flop outputs, so no path exists from pwm_i to rise_o.
    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures PWM high/period counts and recovers a 4-bit duty code
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    pwm_duty_decoder_if.master   res
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [ITER_W-1:0] LAST_IT  = ITER_W'(DIV_ITERS - 1);

    logic s, rise;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_i  (pwm_in),
        .s_o    (s),
        .rise_o (rise)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  hi_ctr_q, hi_ctr_d, per_ctr_q, per_ctr_d;
    logic [CNT_W-1:0]  op_h_q, op_h_d, op_p_q, op_p_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic [DUTY_W-1:0] quo_q, quo_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  high_q, high_d, period_q, period_d;
    logic              valid_q, valid_d, timeout_q, timeout_d, overrun_q, overrun_d;

    logic [CNT_W:0]    rem_sh, rem_nx;
    logic              ge;
    logic [DUTY_W-1:0] quo_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hi_ctr_q  <= '0;
            per_ctr_q <= '0;
            op_h_q    <= '0;
            op_p_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            iter_q    <= '0;
            duty_q    <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_ctr_q  <= hi_ctr_d;
            per_ctr_q <= per_ctr_d;
            op_h_q    <= op_h_d;
            op_p_q    <= op_p_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            iter_q    <= iter_d;
            duty_q    <= duty_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // Counters free-run in every state so the stuck-line check also works from IDLE.
    always_comb begin
        hi_ctr_d  = hi_ctr_q;
        per_ctr_d = per_ctr_q;
        if (rise) begin
            hi_ctr_d  = CNT_W'(1);
            per_ctr_d = CNT_W'(1);
        end else begin
            if (per_ctr_q != CNT_MAX) per_ctr_d = per_ctr_q + CNT_W'(1);
            if (s && hi_ctr_q != CNT_MAX) hi_ctr_d = hi_ctr_q + CNT_W'(1);
        end
    end

    // Restoring division step; H < P keeps the remainder below P, so the shift never overflows.
    always_comb begin
        rem_sh = {rem_q[CNT_W-1:0], 1'b0};
        ge     = (rem_sh >= {1'b0, op_p_q});
        rem_nx = ge ? (rem_sh - {1'b0, op_p_q}) : rem_sh;
        quo_nx = {quo_q[DUTY_W-2:0], ge};
    end

    always_comb begin
        state_d   = state_q;
        op_h_d    = op_h_q;
        op_p_d    = op_p_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        iter_d    = iter_q;
        duty_d    = duty_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        overrun_d = overrun_q;

        if (rise) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            IDLE, MEASURE: begin
                if (rise) begin
                    if (state_q == MEASURE) begin
                        op_h_d  = hi_ctr_q;
                        op_p_d  = per_ctr_q;
                        rem_d   = {1'b0, hi_ctr_q};
                        quo_d   = '0;
                        iter_d  = '0;
                        state_d = DIVIDE;
                    end else begin
                        state_d = MEASURE;
                    end
                end else if (per_ctr_q == TO_VAL && !timeout_q) begin
                    timeout_d = 1'b1;
                    duty_d    = {DUTY_W{s}};
                    high_d    = '0;
                    period_d  = '0;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            DIVIDE: begin
                if (rise) begin
                    overrun_d = 1'b1;
                    op_h_d    = hi_ctr_q;
                    op_p_d    = per_ctr_q;
                    rem_d     = {1'b0, hi_ctr_q};
                    quo_d     = '0;
                    iter_d    = '0;
                end else begin
                    rem_d  = rem_nx;
                    quo_d  = quo_nx;
                    iter_d = iter_q + ITER_W'(1);
                    if (iter_q == LAST_IT) begin
                        duty_d   = quo_nx;
                        high_d   = op_h_q;
                        period_d = op_p_q;
                        valid_d  = 1'b1;
                        state_d  = MEASURE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res.duty       = duty_q;
    assign res.high_cnt   = high_q;
    assign res.period_cnt = period_q;
    assign res.valid      = valid_q;
    assign res.timeout    = timeout_q;
    assign res.overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;
    import pwm_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pwm_in = 1'b0;
    int   cyc    = 0;

    int checks = 0;
    int errors = 0;
    int first_valid_cyc = -1;
    int a2_cyc = 0;

    typedef struct {
        int duty;
        int hi;
        int per;
        int to;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_duty_decoder_if #(.CNT_W(CNT_W)) ifc ();

    pwm_duty_decoder #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .res    (ifc.master)
    );

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int d, input int h, input int p, input int t, input int n);
        exp_t e;
        e.duty = d; e.hi = h; e.per = p; e.to = t;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic drive(input int hi, input int per, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++) begin
                pwm_in = (i < hi);
                @(negedge clk);
            end
    endtask

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_duty"},    int'(ifc.duty),       0);
        check({tag, "_high"},    int'(ifc.high_cnt),   0);
        check({tag, "_period"},  int'(ifc.period_cnt), 0);
        check({tag, "_valid"},   int'(ifc.valid),      0);
        check({tag, "_timeout"}, int'(ifc.timeout),    0);
        check({tag, "_overrun"}, int'(ifc.overrun),    0);
    endtask

    // Monitor: every valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ifc.valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_duty",    int'(ifc.duty),       e.duty);
                check("sb_high",    int'(ifc.high_cnt),   e.hi);
                check("sb_period",  int'(ifc.period_cnt), e.per);
                check("sb_timeout", int'(ifc.timeout),    e.to);
            end
        end
    end

    initial begin
        push(5, 5, 16, 0, 4);
        push(4, 10, 40, 0, 3);
        push(15, 39, 40, 0, 3);
        push(15, 0, 0, 1, 1);
        push(8, 8, 16, 0, 3);
        push(0, 0, 0, 1, 1);
        push(5, 1, 3, 0, 1);
        push(12, 12, 16, 0, 2);

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        drive(5, 16, 1);
        a2_cyc = cyc;
        drive(5, 16, 3);
        check("first_valid_latency", first_valid_cyc, a2_cyc + 7);

        drive(10, 40, 3);
        drive(39, 40, 3);

        hold(1'b1, 150);
        check("stuck_high_timeout", int'(ifc.timeout), 1);
        check("stuck_high_duty",    int'(ifc.duty),    15);

        hold(1'b0, 4);
        drive(8, 16, 1);
        check("timeout_cleared", int'(ifc.timeout), 0);
        drive(8, 16, 3);

        hold(1'b0, 150);
        check("stuck_low_timeout", int'(ifc.timeout), 1);
        check("stuck_low_duty",    int'(ifc.duty),    0);

        drive(1, 3, 6);
        hold(1'b0, 15);
        check("overrun_set", int'(ifc.overrun), 1);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset2");
        rst_n = 1'b1;

        drive(12, 16, 1);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_div");
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        drive(12, 16, 3);
        hold(1'b0, 30);
        check("queue_drained", exp_q.size(), 0);
        check("overrun_after_reset", int'(ifc.overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
